// File: rtl/result_collector_pkg.sv
// Shared miner types for the result collector: hash/nonce widths and the packed result record.
package result_collector_pkg;

  localparam int unsigned HASH_W  = 256;
  localparam int unsigned NONCE_W = 32;
  localparam int unsigned STAT_W  = 32;
  localparam int unsigned DROP_W  = 16;

  typedef struct packed {
    logic [HASH_W-1:0]  hash;
    logic [NONCE_W-1:0] nonce;
  } result_t;

endpackage

// File: rtl/result_fifo.sv
// Show-ahead result FIFO; owns the pointers, occupancy count and full/empty flags.
// A push while full is accepted only when a pop happens on the same edge.
module result_fifo
  import result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  result_t                      wdata,
  output result_t                      rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  result_t             mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/result_collector.sv
// Collects successful supervisor completions into a result FIFO with a sticky overflow flag.
// Optional statistics counters are enabled by defining RESULT_COLLECTOR_STATS_EN.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       process_complete,
  input  logic                       success,
  input  logic [HASH_W-1:0]          hash_out,
  input  logic [NONCE_W-1:0]         nonce_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [HASH_W-1:0]          res_hash,
  output logic [NONCE_W-1:0]         res_nonce,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
`ifdef RESULT_COLLECTOR_STATS_EN
  ,
  output logic [STAT_W-1:0]          jobs_done,
  output logic [STAT_W-1:0]          shares_found,
  output logic [DROP_W-1:0]          drops
`endif
);

  logic    pc_q;
  logic    arm_q;
  logic    ovf_q, ovf_d;
  logic    evt, push, pop, drop;
  logic    fifo_full, fifo_empty;
  result_t wdata, rdata;

  // arm_q blocks the first edge after reset release, so a level that is
  // already high when reset lifts is treated as held rather than as a new edge.
  assign evt  = arm_q & process_complete & ~pc_q;
  assign push = evt & success & ~clear;
  assign pop  = res_valid & res_ready & ~clear;
  assign drop = push & fifo_full & ~pop;

  assign wdata.hash  = hash_out;
  assign wdata.nonce = nonce_out;

  always_comb begin
    ovf_d = ovf_q;
    if (clear)     ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= 1'b0;
      arm_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pc_q  <= process_complete;
      arm_q <= 1'b1;
      ovf_q <= ovf_d;
    end
  end

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign res_hash  = rdata.hash;
  assign res_nonce = rdata.nonce;
  assign overflow  = ovf_q;

`ifdef RESULT_COLLECTOR_STATS_EN
  logic [STAT_W-1:0] jobs_q, jobs_d;
  logic [STAT_W-1:0] shares_q, shares_d;
  logic [DROP_W-1:0] drops_q, drops_d;

  always_comb begin
    jobs_d   = jobs_q;
    shares_d = shares_q;
    drops_d  = drops_q;
    if (clear) begin
      jobs_d   = '0;
      shares_d = '0;
      drops_d  = '0;
    end else begin
      if (evt)                     jobs_d   = jobs_q + 1'b1;
      if (evt && success)          shares_d = shares_q + 1'b1;
      if (drop && (drops_q != '1)) drops_d  = drops_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      jobs_q   <= '0;
      shares_q <= '0;
      drops_q  <= '0;
    end else begin
      jobs_q   <= jobs_d;
      shares_q <= shares_d;
      drops_q  <= drops_d;
    end
  end

  assign jobs_done    = jobs_q;
  assign shares_found = shares_q;
  assign drops        = drops_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: stimulus pushes expected heads, a negedge monitor checks them.
module tb_result_collector;

  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         process_complete;
  logic         success;
  logic [255:0] hash_out;
  logic [31:0]  nonce_out;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] res_hash;
  logic [31:0]  res_nonce;
  logic [2:0]   count;
  logic         overflow;
`ifdef RESULT_COLLECTOR_STATS_EN
  logic [31:0]  jobs_done;
  logic [31:0]  shares_found;
  logic [15:0]  drops;
`endif

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [287:0] exp_q[$];

  result_collector #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .process_complete (process_complete),
    .success          (success),
    .hash_out         (hash_out),
    .nonce_out        (nonce_out),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_hash         (res_hash),
    .res_nonce        (res_nonce),
    .count            (count),
    .overflow         (overflow)
`ifdef RESULT_COLLECTOR_STATS_EN
    ,
    .jobs_done        (jobs_done),
    .shares_found     (shares_found),
    .drops            (drops)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: compares the presented head with the scoreboard front, pops on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL head_unexpected: got nonce %h, required no valid head", res_nonce);
        end else begin
          if ({res_hash, res_nonce} !== exp_q[0]) begin
            errors++;
            $display("FAIL head: got %h/%h, required %h/%h",
                     res_hash, res_nonce, exp_q[0][287:32], exp_q[0][31:0]);
          end
          if (res_ready === 1'b1) void'(exp_q.pop_front());
        end
      end else if (res_valid !== 1'b0 || res_hash !== '0 || res_nonce !== '0) begin
        errors++;
        $display("FAIL empty_head: valid %b nonce %h, required valid 0 and zero head",
                 res_valid, res_nonce);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // One-cycle completion pulse; rdy is held for the sampling edge only.
  task automatic complete(input logic succ, input logic [255:0] h, input logic [31:0] n,
                          input logic accept, input logic rdy);
    process_complete = 1'b1;
    success          = succ;
    hash_out         = h;
    nonce_out        = n;
    res_ready        = rdy;
    if (succ && accept) exp_q.push_back({h, n});
    tick();
    res_ready        = 1'b0;
    process_complete = 1'b0;
    success          = 1'b0;
    tick();
  endtask

  function automatic logic [255:0] hpat(input logic [31:0] n);
    return {8{n ^ 32'hA5A5_0000}};
  endfunction

  initial begin
    logic [255:0] h0;
    h0 = 256'h00000000_839A8E68_86AB5951_D76F4114_75428AFC_90947EE3_20161BBF_18EB6048;
    reset = 1'b0; clear = 1'b0; process_complete = 1'b0; success = 1'b0;
    hash_out = '0; nonce_out = '0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_nonce", {32'd0, res_nonce}, 64'd0);
    chk("rst_hash_nz", {63'd0, |res_hash}, 64'd0);
`ifdef RESULT_COLLECTOR_STATS_EN
    chk("rst_jobs", {32'd0, jobs_done}, 64'd0);
    chk("rst_drops", {48'd0, drops}, 64'd0);
`endif
    reset = 1'b1;
    mon_en = 1'b1;
    tick(); tick();

    // Single share
    process_complete = 1'b1; success = 1'b1; hash_out = h0; nonce_out = 32'h0DC0DE08;
    exp_q.push_back({h0, 32'h0DC0DE08});
    tick();
    chk("share_valid", {63'd0, res_valid}, 64'd1);
    chk("share_count", {61'd0, count}, 64'd1);
    chk("share_nonce", {32'd0, res_nonce}, 64'h0DC0DE08);
    process_complete = 1'b0; success = 1'b0;
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("share_pop_count", {61'd0, count}, 64'd0);

    // Clear, then a failed job
    clear = 1'b1; tick(); clear = 1'b0;
    complete(1'b0, hpat(32'h99), 32'h99, 1'b0, 1'b0);
    chk("fail_count", {61'd0, count}, 64'd0);
`ifdef RESULT_COLLECTOR_STATS_EN
    chk("fail_jobs", {32'd0, jobs_done}, 64'd1);
    chk("fail_shares", {32'd0, shares_found}, 64'd0);
`endif

    // Ready while empty is a no-op
    res_ready = 1'b1; tick(); tick(); res_ready = 1'b0;
    chk("empty_ready_count", {61'd0, count}, 64'd0);
    chk("empty_ready_ovf", {63'd0, overflow}, 64'd0);

    // Overflow: six events, last two dropped
    for (int unsigned i = 1; i <= 6; i++)
      complete(1'b1, hpat(32'(i)), 32'(i), (i <= 4), 1'b0);
    chk("ovf_count", {61'd0, count}, 64'd4);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_head", {32'd0, res_nonce}, 64'd1);
`ifdef RESULT_COLLECTOR_STATS_EN
    chk("ovf_drops", {48'd0, drops}, 64'd2);
`endif
    tick();
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Clear wins over a concurrent completion
    clear = 1'b1; process_complete = 1'b1; success = 1'b1;
    hash_out = hpat(32'h55); nonce_out = 32'h55;
    tick();
    exp_q.delete();
    clear = 1'b0; process_complete = 1'b0; success = 1'b0;
    tick();
    chk("clr_count", {61'd0, count}, 64'd0);
    chk("clr_ovf", {63'd0, overflow}, 64'd0);
    chk("clr_valid", {63'd0, res_valid}, 64'd0);
`ifdef RESULT_COLLECTOR_STATS_EN
    chk("clr_drops", {48'd0, drops}, 64'd0);
    chk("clr_jobs", {32'd0, jobs_done}, 64'd0);
`endif

    // Full with simultaneous push and pop
    for (int unsigned i = 32'h11; i <= 32'h14; i++)
      complete(1'b1, hpat(32'(i)), 32'(i), 1'b1, 1'b0);
    chk("full_count", {61'd0, count}, 64'd4);
    complete(1'b1, hpat(32'h15), 32'h15, 1'b1, 1'b1);
    chk("pp_count", {61'd0, count}, 64'd4);
    chk("pp_ovf", {63'd0, overflow}, 64'd0);
    chk("pp_head", {32'd0, res_nonce}, 64'h12);
    res_ready = 1'b1;
    repeat (4) tick();
    res_ready = 1'b0;
    chk("drain_count", {61'd0, count}, 64'd0);

    // Held level then reset mid-hold
    process_complete = 1'b1; success = 1'b1; hash_out = hpat(32'h77); nonce_out = 32'h77;
    exp_q.push_back({hpat(32'h77), 32'h77});
    repeat (10) tick();
    chk("held_count", {61'd0, count}, 64'd1);
    reset = 1'b0;
    tick();
    exp_q.delete();
    chk("rst_mid_count", {61'd0, count}, 64'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_count", {61'd0, count}, 64'd0);
    chk("post_rst_valid", {63'd0, res_valid}, 64'd0);
    process_complete = 1'b0; success = 1'b0;
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
